// File: rtl/exec_unit.sv
// Multi-cycle execution unit: single-cycle ALU ops plus a bit-serial shift-add multiplier,
// with a registered register-file write-back port.
module exec_unit #(
   parameter  int unsigned WIDTH      = 32,
   localparam int unsigned ADDR_WIDTH = $clog2(WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [ADDR_WIDTH-1:0] rd,
   input  logic [WIDTH-1:0]      rdata1,
   input  logic [WIDTH-1:0]      rdata2,
   output logic                  busy,
   output logic                  write,
   output logic [ADDR_WIDTH-1:0] wnum,
   output logic [WIDTH-1:0]      wdata,
   output logic                  done
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   localparam logic [ADDR_WIDTH-1:0] LAST_STEP = ADDR_WIDTH'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      WB   = 2'b10
   } state_t;

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      a_q, a_d;
   logic [WIDTH-1:0]      b_q, b_d;
   logic [WIDTH-1:0]      acc_q, acc_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] rd_q, rd_d;
   logic                  busy_d, write_d, done_d;
   logic [ADDR_WIDTH-1:0] wnum_d;
   logic [WIDTH-1:0]      wdata_d;

   logic [WIDTH-1:0]      alu_res;
   logic [WIDTH-1:0]      acc_sum;
   logic [ADDR_WIDTH-1:0] shamt;

   // Single-cycle ALU on the live read ports, used only at acceptance
   assign shamt = rdata2[ADDR_WIDTH-1:0];

   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = rdata1 + rdata2;
         OP_SUB:  alu_res = rdata1 - rdata2;
         OP_AND:  alu_res = rdata1 & rdata2;
         OP_OR:   alu_res = rdata1 | rdata2;
         OP_XOR:  alu_res = rdata1 ^ rdata2;
         OP_SLL:  alu_res = rdata1 << shamt;
         OP_SRL:  alu_res = rdata1 >> shamt;
         default: alu_res = '0;
      endcase
   end

   // a_q is the multiplicand shifted left per step, b_q the multiplier shifted right
   assign acc_sum = acc_q + (b_q[0] ? a_q : '0);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      write_d = 1'b0;
      done_d  = 1'b0;
      wnum_d  = wnum;
      wdata_d = wdata;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d   = rdata1;
               b_d   = rdata2;
               rd_d  = rd;
               cnt_d = '0;
               acc_d = '0;
               if (op == OP_MUL) begin
                  state_d = CALC;
               end else begin
                  state_d = WB;
                  wdata_d = alu_res;
                  wnum_d  = rd;
                  write_d = (rd != '0);
                  done_d  = 1'b1;
               end
            end
         end
         CALC: begin
            acc_d = acc_sum;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LAST_STEP) begin
               cnt_d   = '0;
               state_d = WB;
               wdata_d = acc_sum;
               wnum_d  = rd_q;
               write_d = (rd_q != '0);
               done_d  = 1'b1;
            end
         end
         WB: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         rd_q    <= '0;
         busy    <= 1'b0;
         write   <= 1'b0;
         done    <= 1'b0;
         wnum    <= '0;
         wdata   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         busy    <= busy_d;
         write   <= write_d;
         done    <= done_d;
         wnum    <= wnum_d;
         wdata   <= wdata_d;
      end
   end

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: directed corner cases, randomized ops with start noise
// while busy, and a mid-multiply reset abort.
module tb_exec_unit;

   localparam int unsigned W  = 32;
   localparam int unsigned AW = 5;

   logic          clk;
   logic          rst;
   logic          start;
   logic [2:0]    op;
   logic [AW-1:0] rd;
   logic [W-1:0]  rdata1;
   logic [W-1:0]  rdata2;
   logic          busy;
   logic          write;
   logic [AW-1:0] wnum;
   logic [W-1:0]  wdata;
   logic          done;

   exec_unit #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .rd     (rd),
      .rdata1 (rdata1),
      .rdata2 (rdata2),
      .busy   (busy),
      .write  (write),
      .wnum   (wnum),
      .wdata  (wdata),
      .done   (done)
   );

   typedef struct {
      logic [AW-1:0] wnum;
      logic [W-1:0]  wdata;
      logic          write;
      int            cyc;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference result from the operation's arithmetic meaning
   function automatic logic [W-1:0] ref_result(input logic [2:0] o, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
      logic [2*W-1:0] p;
      int             sh;
      sh = int'(b % W);
      p  = (2*W)'(a) * (2*W)'(b);
      case (o)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return a << sh;
         3'd6:    return a >> sh;
         default: return p[W-1:0];
      endcase
   endfunction

   // Caller is at a falling edge with the unit idle; returns at a falling edge with it idle again
   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [AW-1:0] r, input logic [W-1:0] exp_data, input bit noise);
      exp_t e;
      int   lat;
      int   nb;
      lat = (o == 3'b111) ? int'(W) : 0;
      check("idle_before_issue", 32'(busy), 32'd0);
      start  = 1'b1;
      op     = o;
      rdata1 = a;
      rdata2 = b;
      rd     = r;
      e.wnum  = r;
      e.wdata = exp_data;
      e.write = (r != '0);
      e.cyc   = cyc + 1 + lat;
      sb.push_back(e);
      nb = 0;
      @(negedge clk);
      while (busy && nb < 200) begin
         nb++;
         if (noise) begin
            start  = 1'($urandom);
            op     = 3'($urandom);
            rdata1 = $urandom;
            rdata2 = $urandom;
            rd     = AW'($urandom);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("busy_cycles", 32'(nb), 32'(lat + 1));
   endtask

   // Monitor: compare every completion against the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t m;
      if (!rst) begin
         if (done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               m = sb.pop_front();
               check("wnum", 32'(wnum), 32'(m.wnum));
               check("wdata", wdata, m.wdata);
               check("write", 32'(write), 32'(m.write));
               check("done_cycle", 32'(cyc), 32'(m.cyc));
            end
         end else if (write) begin
            check("write_without_done", 32'd1, 32'd0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]    o;
      logic [W-1:0]  a, b;
      logic [AW-1:0] r;

      rst = 1'b1; start = 1'b0; op = '0; rd = '0; rdata1 = '0; rdata2 = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_write", 32'(write), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_wnum", 32'(wnum), 32'd0);
      check("reset_wdata", wdata, 32'd0);
      rst = 1'b0;

      // Directed corner cases, first one accepted on the first edge after release
      issue(3'd0, 32'd5, 32'd7, 5'd1, 32'd12, 1'b0);
      issue(3'd1, 32'd3, 32'd5, 5'd2, 32'hFFFF_FFFE, 1'b0);
      issue(3'd6, 32'h8000_0000, 32'h21, 5'd4, 32'h4000_0000, 1'b0);
      issue(3'd5, 32'h0000_0001, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000, 1'b0);
      issue(3'd7, 32'd6, 32'd7, 5'd3, 32'd42, 1'b1);
      issue(3'd7, 32'h0001_0000, 32'h0001_0000, 5'd5, 32'd0, 1'b0);
      issue(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'd1, 1'b1);
      issue(3'd0, 32'd9, 32'd1, 5'd0, 32'd10, 1'b0);
      issue(3'd0, 32'hFFFF_FFFF, 32'd2, 5'd31, 32'd1, 1'b1);

      // Randomized operations with noise on the inputs while busy
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom);
         a = (i % 3 == 0) ? W'($urandom_range(0, 255)) : $urandom;
         b = (i % 4 == 0) ? W'($urandom_range(0, 63)) : $urandom;
         r = (i % 8 == 0) ? '0 : AW'($urandom);
         issue(o, a, b, r, ref_result(o, a, b), 1'($urandom));
      end

      // Abort a multiply after ten steps with an asynchronous reset
      issue(3'd0, 32'd5, 32'd7, 5'd1, 32'd12, 1'b0);
      start = 1'b1; op = 3'd7; rdata1 = 32'h1234_5677; rdata2 = 32'hFFFF_FFFF; rd = 5'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_write", 32'(write), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_wnum", 32'(wnum), 32'd0);
      check("abort_wdata", wdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("abort_idle", 32'(busy), 32'd0);
      issue(3'd0, 32'd1, 32'd2, 5'd9, 32'd3, 1'b0);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
